fb_write_queue: RTL and testbench
=================================

Name: fb_write_queue

Overview:
- Sits between the UART multibyte receiver and the framebuffer/external cellular RAM.
- Buffers 32-bit received write commands in a small FIFO and drains them as timed, glitch-free write cycles, but only while the VGA timing reports blanking, so display reads are never disturbed.
- The receiver's ack is tied high and cannot be stalled, so overflow is detected and flagged rather than back-pressured.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth; 16 entries.
- ADDR_WIDTH, 15, framebuffer address width; taken from in_data[ADDR_WIDTH+7:8].
- DATA_WIDTH, 8, pixel width; taken from in_data[DATA_WIDTH-1:0].
- WE_CYCLES, 3, cycles wr_en is held high per write (RAM write-pulse width); legal range 1..15.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  32  received command word: [ADDR_WIDTH+7:8] address, [7:0] pixel; other bits ignored.
- in_valid  in  1  single-cycle strobe, one command per strobe.
- in_ready  out  1  high when FIFO not full.
- blank  in  1  high while outside the visible area; enables draining.
- wr_addr  out  ADDR_WIDTH  write address to RAM.
- wr_data  out  DATA_WIDTH  write data to RAM.
- wr_en  out  1  active-high write strobe.
- wr_busy  out  1  high whenever the drain FSM is not IDLE.
- count  out  DEPTH_LOG2+1  current FIFO occupancy, 0..16.
- overflow  out  1  sticky; set when a command is dropped.

Behaviour:
- Reset (async, immediate): FIFO empty, count=0, in_ready=1, FSM=IDLE, wr_en=0, wr_busy=0, wr_addr=0, wr_data=0, overflow=0.
- Reset mid-write: wr_en falls immediately, without waiting for a clock. The partially written word is lost; this is accepted.
- Push: on a clk edge with in_valid=1 and count<16, store {addr,data} at the tail; count+1.
- Push when count==16: command dropped and overflow set to 1. overflow clears only on reset.
- Full is evaluated on the registered count. A push at count==16 is dropped even if a pop happens in the same cycle.
- Push and pop in the same cycle with count in 1..15: both take effect; count unchanged.
- Pointers are DEPTH_LOG2 bits and wrap modulo 16. count is tracked separately; full = count==16, empty = count==0.
- Drain FSM states: IDLE, SETUP, WRITE, HOLD.
  - IDLE: if count!=0 and blank=1, go to SETUP. On that edge, load wr_addr/wr_data from the head entry.
  - SETUP: one cycle; wr_en=0 while address and data settle. Go to WRITE and load the pulse counter with WE_CYCLES-1.
  - WRITE: wr_en=1 for exactly WE_CYCLES cycles. When the counter reaches 0, go to HOLD.
  - HOLD: one cycle; wr_en=0 and wr_addr/wr_data held (data hold time). At the end of HOLD, pop the head (count-1) and return to IDLE.
- wr_en is a registered output; there are no combinational paths from inputs to wr_en.
- wr_addr/wr_data change only on entry to SETUP and are stable from SETUP through HOLD.
- blank falling during SETUP/WRITE/HOLD: the current write completes unchanged. No new write starts until blank=1 in IDLE.
- Latency, FIFO empty and blank=1, push on edge N:
  - wr_addr/wr_data valid after edge N+2;
  - wr_en high for edges N+3 .. N+2+WE_CYCLES;
  - pop at edge N+4+WE_CYCLES.
- Throughput: one write per WE_CYCLES+3 cycles, since IDLE occupies one cycle between words.
- Order: writes leave in exact arrival order; there is no coalescing of duplicate addresses.

Test Plan:
- Single write: blank=1, push in_data=0x00_1234_5A → wr_addr=0x1234, wr_data=0x5A; wr_en high exactly 3 cycles after one SETUP cycle; count returns to 0; wr_busy low afterwards.
- Blank gating: blank=0, push 5 commands → count=5, wr_en never asserts. Raise blank → 5 writes in order, each 6 cycles apart (WE_CYCLES=3).
- Overflow: blank=0, push 17 commands → count=16, in_ready=0, overflow=1, and the 17th never written. Drain with blank=1 → addresses 0..15 written in order; overflow stays 1 until reset.
- Blank falls mid-write: drop blank on the 2nd WRITE cycle → wr_en still high for 3 cycles, HOLD completes, pop occurs; the next queued word waits until blank=1.
- Simultaneous push/pop: count=3, push on the HOLD pop edge → count stays 3. Pointer wrap after 40 total commands → data integrity holds across the wrap.
- Async reset: assert reset during WRITE between clock edges → wr_en=0, count=0, overflow=0 immediately, without a clock edge.

Source files
------------

// File: rtl/fb_write_queue_if.sv
// Command-in / RAM-write-out bundle for the framebuffer write queue.
// Pure wiring; no latency of its own.
// The command side has no stall path: in_ready is status only.
interface fb_write_queue_if #(
    parameter int DEPTH_LOG2 = 4,
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 8
);
    logic [31:0]           in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  blank;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_en;
    logic                  wr_busy;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow;

    // Command source and blanking source side.
    modport master (
        output in_data, in_valid, blank,
        input  in_ready, wr_addr, wr_data, wr_en, wr_busy, count, overflow
    );

    // Queue side.
    modport slave (
        input  in_data, in_valid, blank,
        output in_ready, wr_addr, wr_data, wr_en, wr_busy, count, overflow
    );
endinterface

// File: rtl/fb_write_queue.sv
// Buffers received pixel writes and drains them to the framebuffer RAM during blanking.
// Latency: push on edge N -> address valid after N+2, wr_en high for WE_CYCLES cycles after N+3, pop at N+4+WE_CYCLES.
// Backpressure: none on input (receiver cannot stall); a push while full is dropped and flags sticky overflow.
module fb_write_queue #(
    parameter int DEPTH_LOG2 = 4,
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 8,
    parameter int WE_CYCLES  = 3
) (
    input  logic             clk,
    input  logic             reset,
    fb_write_queue_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int EW    = ADDR_WIDTH + DATA_WIDTH;
    localparam logic [3:0] PULSE_LOAD = 4'(WE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETUP, WRITE, HOLD} state_t;

    logic [EW-1:0]         mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_nxt;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  drop;
    logic                  head_vld;
    logic                  overflow_q;

    state_t                state;
    state_t                state_nxt;
    logic [3:0]            pulse_cnt;
    logic [3:0]            pulse_cnt_nxt;
    logic                  load_head;

    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_pix;
    logic [EW-1:0]         head_ent;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic                  wr_en_q;

    assign cmd_addr = bus.in_data[ADDR_WIDTH+7:8];
    assign cmd_pix  = bus.in_data[DATA_WIDTH-1:0];

    // Full/empty come from the registered occupancy, so a pop in the same
    // cycle never rescues a push that arrives while full.
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = bus.in_valid && !full;
    assign drop  = bus.in_valid && full;
    assign pop   = (state == HOLD);

    assign head_ent = mem[rd_ptr];

    // Occupancy after this edge.
    always_comb begin
        count_nxt = count_q;
        if (push && !pop) begin
            count_nxt = count_q + CW'(1);
        end else if (!push && pop) begin
            count_nxt = count_q - CW'(1);
        end
    end

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_addr, cmd_pix};
        end
    end

    // Pointers, occupancy, head-available flag and sticky overflow.
    // head_vld lags an empty-to-nonempty transition by one cycle so a word is
    // never read out of the array on the same edge it is written; it drops
    // immediately when the last word is popped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            head_vld   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            count_q  <= count_nxt;
            head_vld <= !empty && (count_nxt != '0);
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Drain FSM state and pulse-width counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pulse_cnt <= '0;
        end else begin
            state     <= state_nxt;
            pulse_cnt <= pulse_cnt_nxt;
        end
    end

    // Drain FSM next state: settle, pulse, hold, then pop.
    always_comb begin
        state_nxt     = state;
        pulse_cnt_nxt = pulse_cnt;
        load_head     = 1'b0;
        case (state)
            IDLE: begin
                if (head_vld && bus.blank) begin
                    state_nxt = SETUP;
                    load_head = 1'b1;
                end
            end
            SETUP: begin
                state_nxt     = WRITE;
                pulse_cnt_nxt = PULSE_LOAD;
            end
            WRITE: begin
                if (pulse_cnt == '0) begin
                    state_nxt = HOLD;
                end else begin
                    pulse_cnt_nxt = pulse_cnt - 4'd1;
                end
            end
            HOLD: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // RAM-side outputs: address/data latch on entry to SETUP only, and the
    // strobe is a flop so it is glitch-free and drops on reset without a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
        end else begin
            if (load_head) begin
                wr_addr_q <= head_ent[EW-1:DATA_WIDTH];
                wr_data_q <= head_ent[DATA_WIDTH-1:0];
            end
            wr_en_q <= (state_nxt == WRITE);
        end
    end

    assign bus.in_ready = !full;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_busy  = (state != IDLE);
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_fb_write_queue.sv
// Scoreboard bench for fb_write_queue: driver pushes expected writes, monitor checks RAM-side cycles.
// Timing checks against the documented push-to-pop latency and write spacing.
// Inputs are never stalled; the reference model decides acceptance from its own occupancy.
module tb_fb_write_queue;
    localparam int DL = 4;
    localparam int AW = 15;
    localparam int DW = 8;
    localparam int WE = 3;

    logic clk;
    logic reset;

    fb_write_queue_if #(.DEPTH_LOG2(DL), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    fb_write_queue #(.DEPTH_LOG2(DL), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_CYCLES(WE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int writes_done = 0;
    int rise_q[$];
    logic [AW+DW-1:0] exp_q[$];
    logic model_ovf = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint expv);
        n_cmp++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
        end
    endtask

    // Monitor: every wr_en pulse must match the oldest expected write.
    logic          prev_en = 1'b0;
    logic          prev_busy = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [DW-1:0] prev_data = '0;
    logic [AW-1:0] hold_addr = '0;
    logic [DW-1:0] hold_data = '0;
    int            width = 0;

    always @(negedge clk) begin
        if (reset) begin
            prev_en = 1'b0;
            width   = 0;
        end else begin
            if (bus.wr_en && !prev_en) begin
                rise_q.push_back(cyc);
                chk("setup_cycle_before_write",
                    (prev_busy && prev_addr == bus.wr_addr && prev_data == bus.wr_data) ? 1 : 0, 1);
                chk("write_was_expected", (exp_q.size() != 0) ? 1 : 0, 1);
                if (exp_q.size() != 0) begin
                    logic [AW+DW-1:0] e;
                    e = exp_q.pop_front();
                    chk("wr_addr", bus.wr_addr, e[AW+DW-1:DW]);
                    chk("wr_data", bus.wr_data, e[DW-1:0]);
                end
                hold_addr = bus.wr_addr;
                hold_data = bus.wr_data;
                width = 1;
            end else if (bus.wr_en) begin
                width++;
            end else if (prev_en) begin
                chk("pulse_width", width, WE);
                chk("hold_addr_stable", bus.wr_addr, hold_addr);
                chk("hold_data_stable", bus.wr_data, hold_data);
                chk("hold_busy", bus.wr_busy, 1);
                writes_done++;
            end
            prev_en   = bus.wr_en;
            prev_busy = bus.wr_busy;
            prev_addr = bus.wr_addr;
            prev_data = bus.wr_data;
        end
    end

    // Called at a negedge; the command lands on the next posedge. The model
    // accepts while it holds fewer than 16 words (only used where no write is in flight
    // or occupancy is kept well below full).
    task automatic push_cmd(input logic [31:0] d);
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        if (exp_q.size() < 16) exp_q.push_back({d[AW+7:8], d[DW-1:0]});
        else model_ovf = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (bus.count == 0 && !bus.wr_busy && !bus.wr_en) done = 1;
        end
        chk("drain_within_budget", done, 1);
    endtask

    task automatic wait_en(input int budget);
        bit done;
        done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (bus.wr_en) done = 1;
        end
        chk("wr_en_within_budget", done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        reset = 1'b1;
        bus.blank = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_count", bus.count, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_wr_en", bus.wr_en, 0);
        chk("rst_wr_busy", bus.wr_busy, 0);
        chk("rst_wr_addr", bus.wr_addr, 0);
        chk("rst_wr_data", bus.wr_data, 0);
        chk("rst_overflow", bus.overflow, 0);
        reset = 1'b0;
        @(negedge clk);

        // Single write with cycle-exact latency.
        bus.blank = 1'b1;
        push_cmd(32'h0012345A);
        for (int k = 0; k <= WE + 5; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("lat_wr_en_k%0d", k), bus.wr_en, (k >= 3 && k <= 2 + WE) ? 1 : 0);
            chk($sformatf("lat_busy_k%0d", k), bus.wr_busy, (k >= 2 && k <= 3 + WE) ? 1 : 0);
            chk($sformatf("lat_count_k%0d", k), bus.count, (k < 4 + WE) ? 1 : 0);
            if (k == 2) begin
                chk("lat_addr_at_setup", bus.wr_addr, 15'h1234);
                chk("lat_data_at_setup", bus.wr_data, 8'h5A);
            end
        end

        // Blank gating and back-to-back spacing.
        bus.blank = 1'b0;
        w0 = writes_done;
        for (int i = 0; i < 5; i++) push_cmd($urandom);
        repeat (10) @(negedge clk);
        chk("gated_count", bus.count, exp_q.size());
        chk("gated_no_writes", writes_done - w0, 0);
        rise_q.delete();
        bus.blank = 1'b1;
        wait_idle(200);
        chk("gated_writes_done", writes_done - w0, 5);
        chk("gated_rise_count", rise_q.size(), 5);
        for (int i = 1; i < rise_q.size(); i++)
            chk($sformatf("spacing_%0d", i), rise_q[i] - rise_q[i-1], WE + 3);

        // Overflow: 17th command is dropped.
        bus.blank = 1'b0;
        for (int i = 0; i < 17; i++) push_cmd((i << 8) | ((i * 7 + 3) & 8'hFF));
        chk("full_count", bus.count, 16);
        chk("full_in_ready", bus.in_ready, 0);
        chk("full_overflow", bus.overflow, model_ovf);
        bus.blank = 1'b1;
        wait_idle(400);
        chk("ovf_scoreboard_empty", exp_q.size(), 0);
        chk("ovf_sticky", bus.overflow, 1);
        chk("ovf_in_ready_after", bus.in_ready, 1);

        // Blank falls on the 2nd WRITE cycle; current write completes, next waits.
        bus.blank = 1'b0;
        w0 = writes_done;
        push_cmd($urandom);
        push_cmd($urandom);
        bus.blank = 1'b1;
        wait_en(20);
        @(negedge clk);
        bus.blank = 1'b0;
        repeat (12) @(negedge clk);
        chk("midblank_count", bus.count, 1);
        chk("midblank_busy", bus.wr_busy, 0);
        chk("midblank_writes", writes_done - w0, 1);
        bus.blank = 1'b1;
        wait_idle(100);

        // Push lands on the pop edge with count=3.
        bus.blank = 1'b0;
        for (int i = 0; i < 3; i++) push_cmd($urandom);
        chk("pp_count_before", bus.count, 3);
        bus.blank = 1'b1;
        wait_en(20);
        begin
            bit fell;
            fell = 0;
            for (int i = 0; i < 20 && !fell; i++) begin
                @(negedge clk);
                if (!bus.wr_en) fell = 1;
            end
            chk("pp_reach_hold", fell, 1);
        end
        push_cmd($urandom);
        chk("pp_count_after", bus.count, 3);
        wait_idle(200);

        // Randomized traffic with blank toggling; crosses pointer wrap repeatedly.
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 5) == 0) bus.blank = ~bus.blank;
            if ($urandom_range(0, 1) == 1 && exp_q.size() < 14) push_cmd($urandom);
            else @(negedge clk);
        end
        bus.blank = 1'b1;
        wait_idle(2000);
        chk("rand_scoreboard_empty", exp_q.size(), 0);
        chk("rand_count", bus.count, 0);

        // Asynchronous reset between clock edges during WRITE.
        bus.blank = 1'b0;
        push_cmd($urandom);
        push_cmd($urandom);
        bus.blank = 1'b1;
        wait_en(20);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_wr_en", bus.wr_en, 0);
        chk("arst_count", bus.count, 0);
        chk("arst_overflow", bus.overflow, 0);
        chk("arst_busy", bus.wr_busy, 0);
        chk("arst_in_ready", bus.in_ready, 1);
        exp_q.delete();
        model_ovf = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        push_cmd(32'h00_7FFF_C3);
        wait_idle(100);
        chk("post_rst_scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
